rat_addsub_pipe: RTL

- Parametrised, fully pipelined add/subtract unit for signed rationals (num/den pairs); next generation of the team's fixed-width, fixed-mode rational subtractor.
- Adds a per-transaction op select, valid/ready flow control with backpressure, a same-denominator fast path, denominator sign normalisation and error flags.
- Sits between the rational operand fetch logic and the rat_mul/rat_reduce stages of the rational datapath.

---
 rtl/rat_pkg.sv | 24 ++
 rtl/rat_pipe_ctl.sv | 53 +++++
 rtl/rat_addsub_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rat_pkg.sv
`default_nettype none
// =============================================================================
// rat_pkg : shared op encoding, default widths and stage flag payload
//           for the rational datapath.                         Rev 1.0
// =============================================================================
package rat_pkg;

    localparam int RAT_WIDTH_DEF     = 32;
    localparam int RAT_TAG_WIDTH_DEF = 4;

    typedef enum logic {
        RAT_OP_ADD = 1'b0,
        RAT_OP_SUB = 1'b1
    } rat_op_e;

    // Width-independent part of the S1 payload; the products travel alongside.
    typedef struct packed {
        rat_op_e op;
        logic    same;
        logic    div0;
    } rat_flags_t;

endpackage
`default_nettype wire

// File: rtl/rat_pipe_ctl.sv
`default_nettype none
// =============================================================================
// rat_pipe_ctl : three-stage valid/ready chain with bubble collapse and
//                per-stage payload load enables.               Rev 1.0
// =============================================================================
module rat_pipe_ctl (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic ready_o,
    output logic valid_o,
    input  logic ready_i,
    output logic en1_o,
    output logic en2_o,
    output logic en3_o
);

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic rdy1, rdy2, rdy3;

    assign rdy3 = !v3_q || ready_i;
    assign rdy2 = !v2_q || rdy3;
    assign rdy1 = !v1_q || rdy2;

    assign ready_o = rdy1;
    assign valid_o = v3_q;

    // Payload registers only capture when a real item moves into the stage.
    assign en1_o = rdy1 && valid_i;
    assign en2_o = rdy2 && v1_q;
    assign en3_o = rdy3 && v2_q;

    always_comb begin
        v1_d = rdy1 ? valid_i : v1_q;
        v2_d = rdy2 ? v1_q    : v2_q;
        v3_d = rdy3 ? v2_q    : v3_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rat_addsub_pipe.sv
`default_nettype none
// =============================================================================
// rat_addsub_pipe : 3-stage pipelined signed rational add/subtract with
//                   valid/ready flow control. Optional tag: RAT_ADDSUB_TAG_EN.
//                                                              Rev 1.0
// =============================================================================
module rat_addsub_pipe
    import rat_pkg::*;
#(
    parameter int WIDTH     = RAT_WIDTH_DEF,
    parameter int TAG_WIDTH = RAT_TAG_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_op,
    input  logic signed [WIDTH-1:0] l_num,
    input  logic signed [WIDTH-1:0] l_den,
    input  logic signed [WIDTH-1:0] r_num,
    input  logic signed [WIDTH-1:0] r_den,
`ifdef RAT_ADDSUB_TAG_EN
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic [TAG_WIDTH-1:0]    out_tag,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] s_num,
    output logic signed [WIDTH-1:0] s_den,
    output logic                    s_ovf,
    output logic                    s_div0
);

    localparam int PW = 2 * WIDTH;
    localparam int XW = 2 * WIDTH + 1;
    localparam logic signed [XW-1:0] C_MAX = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] C_MIN = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic en1, en2, en3;

    rat_pipe_ctl u_ctl (
        .clk     (clk),
        .rst     (rst),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .en1_o   (en1),
        .en2_o   (en2),
        .en3_o   (en3)
    );

    // ---------------- S1: multiply ----------------
    logic signed [PW-1:0]    l_num_x, l_den_x, r_num_x, r_den_x;
    rat_flags_t              flags1_d, flags1_q;
    logic signed [PW-1:0]    p1_d, p2_d, p3_d;
    logic signed [PW-1:0]    p1_q, p2_q, p3_q;
    logic signed [WIDTH-1:0] lnum1_q, rnum1_q, lden1_q;

    assign l_num_x = {{WIDTH{l_num[WIDTH-1]}}, l_num};
    assign l_den_x = {{WIDTH{l_den[WIDTH-1]}}, l_den};
    assign r_num_x = {{WIDTH{r_num[WIDTH-1]}}, r_num};
    assign r_den_x = {{WIDTH{r_den[WIDTH-1]}}, r_den};

    always_comb begin
        flags1_d.op   = rat_op_e'(in_op);
        flags1_d.same = (l_den == r_den);
        flags1_d.div0 = (l_den == '0) || (r_den == '0);
        p1_d          = l_num_x * r_den_x;
        p2_d          = r_num_x * l_den_x;
        p3_d          = l_den_x * r_den_x;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags1_q <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            lnum1_q  <= '0;
            rnum1_q  <= '0;
            lden1_q  <= '0;
        end else if (en1) begin
            flags1_q <= flags1_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            lnum1_q  <= l_num;
            rnum1_q  <= r_num;
            lden1_q  <= l_den;
        end
    end

    // ---------------- S2: combine at 2*WIDTH+1 bits ----------------
    logic signed [XW-1:0] opa, opb;
    logic signed [XW-1:0] n2_d, d2_d, n2_q, d2_q;
    logic                 div0_2_q;

    always_comb begin
        if (flags1_q.same) begin
            opa  = {{(XW-WIDTH){lnum1_q[WIDTH-1]}}, lnum1_q};
            opb  = {{(XW-WIDTH){rnum1_q[WIDTH-1]}}, rnum1_q};
            d2_d = {{(XW-WIDTH){lden1_q[WIDTH-1]}}, lden1_q};
        end else begin
            opa  = {p1_q[PW-1], p1_q};
            opb  = {p2_q[PW-1], p2_q};
            d2_d = {p3_q[PW-1], p3_q};
        end
        n2_d = (flags1_q.op == RAT_OP_SUB) ? (opa - opb) : (opa + opb);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n2_q     <= '0;
            d2_q     <= '0;
            div0_2_q <= 1'b0;
        end else if (en2) begin
            n2_q     <= n2_d;
            d2_q     <= d2_d;
            div0_2_q <= flags1_q.div0;
        end
    end

    // ---------------- S3: sign-normalise and narrow ----------------
    logic signed [XW-1:0]    n3, d3;
    logic                    ovf3_d;
    logic signed [WIDTH-1:0] s_num_q, s_den_q;
    logic                    s_ovf_q, s_div0_q;

    // The extra intermediate bit keeps -(most-negative product) representable.
    always_comb begin
        n3 = n2_q;
        d3 = d2_q;
        if (d2_q[XW-1]) begin
            n3 = -n2_q;
            d3 = -d2_q;
        end
        ovf3_d = (n3 > C_MAX) || (n3 < C_MIN) || (d3 > C_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_num_q  <= '0;
            s_den_q  <= '0;
            s_ovf_q  <= 1'b0;
            s_div0_q <= 1'b0;
        end else if (en3) begin
            s_num_q  <= n3[WIDTH-1:0];
            s_den_q  <= d3[WIDTH-1:0];
            s_ovf_q  <= ovf3_d;
            s_div0_q <= div0_2_q;
        end
    end

    assign s_num  = s_num_q;
    assign s_den  = s_den_q;
    assign s_ovf  = s_ovf_q;
    assign s_div0 = s_div0_q;

`ifdef RAT_ADDSUB_TAG_EN
    logic [TAG_WIDTH-1:0] tag1_q, tag2_q, tag3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            if (en1) tag1_q <= in_tag;
            if (en2) tag2_q <= tag1_q;
            if (en3) tag3_q <= tag2_q;
        end
    end

    assign out_tag = tag3_q;
`endif

endmodule
`default_nettype wire
